// File: rtl/read_bram_scalar2vector.sv
// -----------------------------------------------------------------------------
// read_bram_scalar2vector
//
// Purpose:
//   Pulls 32-bit words out of a local BRAM and packs each group of 16
//   consecutive words into one 512-bit line. Every packed line is emitted on
//   the read-side stream as a single-cycle out_valid pulse. This is the mirror
//   of the vector->scalar BRAM writer. Word i of a line sits in
//   bits [i*32+31 -: 32].
//
// Parameters:
//   RD_LATENCY  BRAM read latency in cycles, from re/raddr to valid rdata (1..4)
//   ADDR_W      BRAM word-address width
//
// Ports:
//   clk             clock, all logic on posedge
//   reset_n         synchronous reset, active low
//   op_start        start pulse, sampled only while idle
//   configreg       [15:0] word offset, [31:16] length in 512-bit lines
//   busy            high whenever the engine is not idle
//   bram_re         BRAM read enable
//   bram_raddr      BRAM word read address
//   bram_rdata      BRAM read data, valid RD_LATENCY cycles after bram_re
//   out_valid       one-cycle pulse per packed line
//   out_data        packed line, held stable between pulses
//   out_almostfull  consumer backpressure, no out_valid is issued while high
//   op_done         (only with S2V_DONE_PULSE_EN) one-cycle completion pulse
//
// Optional feature:
//   Define S2V_DONE_PULSE_EN to add the op_done output. Without it, completion
//   can only be seen as busy falling.
// -----------------------------------------------------------------------------
module read_bram_scalar2vector #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic [31:0]       configreg,
    output logic              busy,
    output logic              bram_re,
    output logic [ADDR_W-1:0] bram_raddr,
    input  logic [31:0]       bram_rdata,
    output logic              out_valid,
    output logic [511:0]      out_data,
    input  logic              out_almostfull
`ifdef S2V_DONE_PULSE_EN
    ,
    output logic              op_done
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [15:0]     offset_reg;
    logic [15:0]     length_reg;
    logic [15:0]     line_cnt_reg;
    logic [3:0]      issue_pos_reg;
    logic [3:0]      recv_pos_reg;
    logic [511:0]    line_buf_reg;

    // Return-path tags: bit/slot i describes the read issued i+1 cycles ago.
    // The oldest stage lines up with the cycle in which bram_rdata is valid.
    logic [RD_LATENCY-1:0] tag_re_reg;
    logic [3:0]            tag_slot_reg [RD_LATENCY];

    logic       ret_valid;
    logic [3:0] ret_slot;

    assign ret_valid = tag_re_reg[RD_LATENCY-1];
    assign ret_slot  = tag_slot_reg[RD_LATENCY-1];
    assign busy      = (state_reg != IDLE);

    // Word address of slot pos in the given line. The sum is formed in 32 bits
    // and then truncated to ADDR_W by the caller, so ranges that run past the
    // top of the BRAM wrap silently to address 0.
    function automatic logic [31:0] word_addr(input logic [15:0] off,
                                              input logic [15:0] line,
                                              input logic [3:0]  pos);
        word_addr = {16'd0, off} + ({16'd0, line} << 4) + {28'd0, pos};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            offset_reg    <= '0;
            length_reg    <= '0;
            line_cnt_reg  <= '0;
            issue_pos_reg <= '0;
            recv_pos_reg  <= '0;
            line_buf_reg  <= '0;
            bram_re       <= 1'b0;
            bram_raddr    <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            tag_re_reg    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_slot_reg[i] <= '0;
            end
`ifdef S2V_DONE_PULSE_EN
            op_done       <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef S2V_DONE_PULSE_EN
            op_done   <= 1'b0;
`endif

            tag_re_reg[0]   <= bram_re;
            tag_slot_reg[0] <= issue_pos_reg;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_re_reg[i]   <= tag_re_reg[i-1];
                tag_slot_reg[i] <= tag_slot_reg[i-1];
            end
            if (ret_valid) begin
                line_buf_reg[{ret_slot, 5'd0} +: 32] <= bram_rdata;
                recv_pos_reg <= recv_pos_reg + 4'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (op_start) begin
                        offset_reg    <= configreg[15:0];
                        length_reg    <= configreg[31:16];
                        line_cnt_reg  <= '0;
                        issue_pos_reg <= '0;
                        recv_pos_reg  <= '0;
                        if (configreg[31:16] != 16'd0) begin
                            state_reg  <= FETCH;
                            bram_re    <= 1'b1;
                            bram_raddr <= ADDR_W'(word_addr(configreg[15:0], 16'd0, 4'd0));
                        end else begin
`ifdef S2V_DONE_PULSE_EN
                            op_done <= 1'b1;
`endif
                        end
                    end
                end

                FETCH: begin
                    if (issue_pos_reg == 4'd15) begin
                        bram_re   <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        issue_pos_reg <= issue_pos_reg + 4'd1;
                        bram_raddr    <= ADDR_W'(word_addr(offset_reg, line_cnt_reg,
                                                           issue_pos_reg + 4'd1));
                    end
                end

                DRAIN: begin
                    if (ret_valid && (recv_pos_reg == 4'd15)) begin
                        state_reg <= SEND;
                    end
                end

                SEND: begin
                    if (!out_almostfull) begin
                        out_valid    <= 1'b1;
                        out_data     <= line_buf_reg;
                        line_cnt_reg <= line_cnt_reg + 16'd1;
                        if (line_cnt_reg == (length_reg - 16'd1)) begin
                            state_reg <= IDLE;
`ifdef S2V_DONE_PULSE_EN
                            op_done   <= 1'b1;
`endif
                        end else begin
                            state_reg     <= FETCH;
                            issue_pos_reg <= '0;
                            bram_re       <= 1'b1;
                            bram_raddr    <= ADDR_W'(word_addr(offset_reg,
                                                               line_cnt_reg + 16'd1, 4'd0));
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_bram_scalar2vector.sv
// -----------------------------------------------------------------------------
// tb_read_bram_scalar2vector
//
// Purpose:
//   Self-checking bench for read_bram_scalar2vector. The BRAM model holds
//   BRAM[w] = w. Each start pushes the expected address sequence and the
//   expected packed lines into queues. Negedge monitors pop those queues and
//   compare them against bram_raddr and out_data.
// -----------------------------------------------------------------------------
module tb_read_bram_scalar2vector;

  localparam int RDL = 1;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          op_start;
  logic [31:0]   configreg;
  logic          busy;
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic [31:0]   bram_rdata;
  logic          out_valid;
  logic [511:0]  out_data;
  logic          out_almostfull;
`ifdef S2V_DONE_PULSE_EN
  logic          op_done;
  int            done_cnt = 0;
`endif

  always #5 clk = ~clk;

  read_bram_scalar2vector #(.RD_LATENCY(RDL), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .op_start       (op_start),
    .configreg      (configreg),
    .busy           (busy),
    .bram_re        (bram_re),
    .bram_raddr     (bram_raddr),
    .bram_rdata     (bram_rdata),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_almostfull (out_almostfull)
`ifdef S2V_DONE_PULSE_EN
    ,
    .op_done        (op_done)
`endif
  );

  // BRAM model: BRAM[w] = w. Read data becomes valid RDL cycles after the
  // cycle in which the read is issued.
  logic [31:0] rd_pipe [RDL];
  always @(posedge clk) begin
    rd_pipe[0] <= 32'(bram_raddr);
    for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bram_rdata = rd_pipe[RDL-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] addr_q [$];
  logic [511:0]  line_q [$];
  int            out_cnt = 0;
  int            re_cnt  = 0;

  // Scoreboard monitors. They sample away from the active edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bram_re) begin
        re_cnt++;
        check("raddr_expected", 512'(addr_q.size() != 0), 512'(1));
        if (addr_q.size() != 0) check("raddr", 512'(bram_raddr), 512'(addr_q.pop_front()));
      end
      if (out_valid) begin
        out_cnt++;
        check("line_expected", 512'(line_q.size() != 0), 512'(1));
        if (line_q.size() != 0) check("line_data", out_data, line_q.pop_front());
      end
`ifdef S2V_DONE_PULSE_EN
      if (op_done) done_cnt++;
`endif
    end
  end

  // Pushes the expected results, then pulses op_start for one cycle.
  // The task returns 1 time unit after the edge that samples op_start.
  task automatic start_op(input logic [15:0] off, input logic [15:0] len);
    for (int k = 0; k < int'(len); k++) begin
      logic [511:0] ln;
      ln = '0;
      for (int i = 0; i < 16; i++) begin
        logic [15:0] a;
        a = off + 16'(k * 16 + i);
        addr_q.push_back(a);
        ln[i*32 +: 32] = {16'h0, a};
      end
      line_q.push_back(ln);
    end
    @(posedge clk); #1;
    op_start  = 1'b1;
    configreg = {len, off};
    @(posedge clk); #1;
    op_start  = 1'b0;
    configreg = 32'h0;
  endtask

  // Counts edges until busy drops, with a bound. Then lets the monitors
  // catch the final out_valid pulse.
  task automatic wait_idle(input int maxc, output int cyc);
    cyc = 0;
    while (busy && cyc < maxc) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("idle_timeout", 512'(busy), 512'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      512'(busy),       512'(0));
    check({tag, "_bram_re"},   512'(bram_re),    512'(0));
    check({tag, "_out_valid"}, 512'(out_valid),  512'(0));
    check({tag, "_raddr"},     512'(bram_raddr), 512'(0));
    check({tag, "_out_data"},  out_data,         512'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int re_snap;
    int out_snap;

    reset_n        = 1'b0;
    op_start       = 1'b0;
    configreg      = 32'h0;
    out_almostfull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // T1: a single line at offset 0x10. Busy drops 19 cycles after op_start
    // is raised, which is 17+RDL edges after the edge that samples it.
    out_cnt = 0;
    start_op(16'h0010, 16'd1);
    check("t1_busy_start", 512'(busy), 512'(1));
    wait_idle(100, cyc);
    check("t1_busy_cycles", 512'(cyc), 512'(17 + RDL));
    check("t1_out_cnt", 512'(out_cnt), 512'(1));
    check("t1_lines_left", 512'(line_q.size()), 512'(0));

    // T2: three lines back to back, reads 0..47 with no gaps.
    out_cnt = 0;
    re_cnt  = 0;
    start_op(16'h0000, 16'd3);
    wait_idle(300, cyc);
    check("t2_busy_cycles", 512'(cyc), 512'(3 * (17 + RDL)));
    check("t2_out_cnt", 512'(out_cnt), 512'(3));
    check("t2_re_cnt", 512'(re_cnt), 512'(48));
    check("t2_addr_left", 512'(addr_q.size()), 512'(0));

    // T3: backpressure held for 50 cycles while line 0 waits in SEND.
    out_cnt        = 0;
    out_almostfull = 1'b1;
    start_op(16'h0100, 16'd2);
    repeat (20) @(posedge clk);
    #1;
    re_snap  = re_cnt;
    out_snap = out_cnt;
    repeat (50) @(posedge clk);
    #1;
    check("t3_hold_no_re", 512'(re_cnt - re_snap), 512'(0));
    check("t3_hold_no_valid", 512'(out_cnt - out_snap), 512'(0));
    check("t3_hold_busy", 512'(busy), 512'(1));
    out_almostfull = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t3_release_valid", 512'(out_valid), 512'(1));
    wait_idle(100, cyc);
    check("t3_out_cnt", 512'(out_cnt), 512'(2));

    // T4: the address range wraps past 0xFFFF.
    out_cnt = 0;
    start_op(16'hFFF8, 16'd1);
    wait_idle(100, cyc);
    check("t4_out_cnt", 512'(out_cnt), 512'(1));
    check("t4_addr_left", 512'(addr_q.size()), 512'(0));

    // T5: reset pulsed during the fetch of line 1 of 3.
    out_cnt = 0;
    start_op(16'h0200, 16'd3);
    repeat (23) @(posedge clk);
    #1;
    check("t5_first_line", 512'(out_cnt), 512'(1));
    reset_n = 1'b0;
    addr_q.delete();
    line_q.delete();
    @(posedge clk);
    #1;
    check_all_zero("t5_reset");
    reset_n = 1'b1;
    out_cnt = 0;
    re_cnt  = 0;
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_valid_after", 512'(out_cnt), 512'(0));
    check("t5_no_re_after", 512'(re_cnt), 512'(0));
    start_op(16'h0300, 16'd1);
    wait_idle(100, cyc);
    check("t5_restart_out_cnt", 512'(out_cnt), 512'(1));

    // T6: length 0 makes no BRAM access. An op_start raised while busy is
    // ignored.
    out_cnt = 0;
    re_cnt  = 0;
    start_op(16'h0040, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check("t6_len0_busy", 512'(busy), 512'(0));
      @(posedge clk); #1;
    end
    check("t6_len0_no_re", 512'(re_cnt), 512'(0));
    start_op(16'h0050, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    op_start  = 1'b1;
    configreg = {16'd5, 16'h0999};
    @(posedge clk); #1;
    op_start  = 1'b0;
    configreg = 32'h0;
    wait_idle(100, cyc);
    check("t6_out_cnt", 512'(out_cnt), 512'(1));
    check("t6_re_cnt", 512'(re_cnt), 512'(16));
    check("t6_addr_left", 512'(addr_q.size()), 512'(0));
    check("t6_lines_left", 512'(line_q.size()), 512'(0));

`ifdef S2V_DONE_PULSE_EN
    // The completed operations are T1, T2, T3, T4, the T5 restart, and both
    // starts in T6. The aborted T5 run does not count.
    check("op_done_count", 512'(done_cnt), 512'(7));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
